// File: rtl/wired_lsu_bus_mgr.sv
// wired_lsu_bus_mgr: bus manager behind the load/store unit.
// It serves cache-line refills, uncached loads and uncached stores. A refill
// writes each returning beat straight into the data SRAM and then writes the tag.
// Optional feature macro: WIRED_LSU_BUS_EARLY_RESP_EN. When it is defined, an
// uncached store responds as soon as its write address/data is accepted and
// does not wait for the write response.
module wired_lsu_bus_mgr (
  input  logic         clk,
  input  logic         rst_n,
  // request side
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  logic [1:0]   req_op_i,
  input  logic [31:0]  req_paddr_i,
  input  logic [1:0]   req_way_i,
  input  logic         req_wp_i,
  input  logic [31:0]  req_wdata_i,
  input  logic [3:0]   req_strb_i,
  // response side
  output logic         resp_valid_o,
  input  logic         resp_ready_i,
  output logic [31:0]  resp_rdata_o,
  // memory read channel
  output logic         mem_ar_valid_o,
  input  logic         mem_ar_ready_i,
  output logic [31:0]  mem_ar_addr_o,
  output logic [1:0]   mem_ar_len_o,
  input  logic         mem_r_valid_i,
  input  logic [31:0]  mem_r_data_i,
  // memory write channel
  output logic         mem_aw_valid_o,
  input  logic         mem_aw_ready_i,
  output logic [31:0]  mem_aw_addr_o,
  output logic [31:0]  mem_w_data_o,
  output logic [3:0]   mem_w_strb_o,
  input  logic         mem_b_valid_i,
  // SRAM write / snoop side
  output logic [11:0]  snoop_daddr_o,
  output logic [1:0]   snoop_dway_o,
  output logic [127:0] snoop_d_o,
  output logic [15:0]  snoop_dstrb_o,
  output logic [11:0]  snoop_taddr_o,
  output logic [3:0]   snoop_twe_o,
  output logic [21:0]  snoop_tag_o
);

  localparam logic [1:0] OP_REFILL = 2'd0;
  localparam logic [1:0] OP_LOAD   = 2'd1;
  localparam logic [1:0] OP_STORE  = 2'd2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    AR    = 3'd1,
    RDATA = 3'd2,
    TAGWR = 3'd3,
    AW    = 3'd4,
    BWAIT = 3'd5,
    RESP  = 3'd6
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [1:0]    op_r;
  logic [31:0]   paddr_r;
  logic [1:0]    way_r;
  logic          wp_r;
  logic [31:0]   wdata_r;
  logic [3:0]    strb_r;
  logic [1:0]    beat_r;
  logic [1:0]    beat_s;
  logic [31:0]   rdata_r;
  logic [31:0]   rdata_s;
  logic          capture_s;
  logic          req_ready_s;
  logic          resp_valid_s;
  logic          ar_valid_s;
  logic          aw_valid_s;
  logic [127:0]  snoop_d_s;
  logic [15:0]   snoop_dstrb_s;
  logic [3:0]    snoop_twe_s;

  // Turns a way number into the tag write enable for that way.
  function automatic logic [3:0] way_onehot(input logic [1:0] way);
    logic [3:0] oh;
    case (way)
      2'd0:    oh = 4'b0001;
      2'd1:    oh = 4'b0010;
      2'd2:    oh = 4'b0100;
      2'd3:    oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

  // State, beat counter, response data and captured request fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      beat_r  <= 2'd0;
      rdata_r <= 32'h0;
      op_r    <= 2'd0;
      paddr_r <= 32'h0;
      way_r   <= 2'd0;
      wp_r    <= 1'b0;
      wdata_r <= 32'h0;
      strb_r  <= 4'h0;
    end else begin
      state_r <= state_s;
      beat_r  <= beat_s;
      rdata_r <= rdata_s;
      if (capture_s) begin
        op_r    <= req_op_i;
        paddr_r <= req_paddr_i;
        way_r   <= req_way_i;
        wp_r    <= req_wp_i;
        wdata_r <= req_wdata_i;
        strb_r  <= req_strb_i;
      end
    end
  end

  // Next state, handshake outputs and SRAM write strobes for the current state.
  always_comb begin
    state_s       = state_r;
    beat_s        = beat_r;
    rdata_s       = rdata_r;
    capture_s     = 1'b0;
    req_ready_s   = 1'b0;
    resp_valid_s  = 1'b0;
    ar_valid_s    = 1'b0;
    aw_valid_s    = 1'b0;
    snoop_d_s     = 128'h0;
    snoop_dstrb_s = 16'h0;
    snoop_twe_s   = 4'h0;
    case (state_r)
      IDLE: begin
        req_ready_s = 1'b1;
        if (req_valid_i) begin
          capture_s = 1'b1;
          beat_s    = 2'd0;
          rdata_s   = 32'h0;
          case (req_op_i)
            OP_REFILL, OP_LOAD: state_s = AR;
            OP_STORE:           state_s = AW;
            default:            state_s = RESP;
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      AR: begin
        ar_valid_s = 1'b1;
        if (mem_ar_ready_i) begin
          state_s = RDATA;
        end else begin
          state_s = AR;
        end
      end
      RDATA: begin
        if (mem_r_valid_i) begin
          if (op_r == OP_REFILL) begin
            // Each beat lands directly in its word lane of the line.
            snoop_d_s[{beat_r, 5'b00000} +: 32]    = mem_r_data_i;
            snoop_dstrb_s[{beat_r, 2'b00} +: 4]    = 4'hF;
            if (beat_r == paddr_r[3:2]) begin
              rdata_s = mem_r_data_i;
            end else begin
              rdata_s = rdata_r;
            end
            beat_s = beat_r + 2'd1;
            if (beat_r == 2'd3) begin
              state_s = TAGWR;
            end else begin
              state_s = RDATA;
            end
          end else begin
            rdata_s = mem_r_data_i;
            state_s = RESP;
          end
        end else begin
          state_s = RDATA;
        end
      end
      TAGWR: begin
        snoop_twe_s = way_onehot(way_r);
        state_s     = RESP;
      end
      AW: begin
        aw_valid_s = 1'b1;
        if (mem_aw_ready_i) begin
`ifdef WIRED_LSU_BUS_EARLY_RESP_EN
          state_s = RESP;
`else
          state_s = BWAIT;
`endif
        end else begin
          state_s = AW;
        end
      end
      BWAIT: begin
        if (mem_b_valid_i) begin
          state_s = RESP;
        end else begin
          state_s = BWAIT;
        end
      end
      RESP: begin
        resp_valid_s = 1'b1;
        if (resp_ready_i) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign req_ready_o    = req_ready_s;
  assign resp_valid_o   = resp_valid_s;
  assign resp_rdata_o   = rdata_r;

  // Refills fetch the whole aligned line; uncached loads fetch exactly one word.
  assign mem_ar_valid_o = ar_valid_s;
  assign mem_ar_addr_o  = (op_r == OP_REFILL) ? {paddr_r[31:4], 4'h0} : paddr_r;
  assign mem_ar_len_o   = (op_r == OP_REFILL) ? 2'd3 : 2'd0;

  assign mem_aw_valid_o = aw_valid_s;
  assign mem_aw_addr_o  = paddr_r;
  assign mem_w_data_o   = wdata_r;
  assign mem_w_strb_o   = strb_r;

  // Addresses and data are only meaningful while a strobe/enable is set.
  assign snoop_daddr_o  = {paddr_r[11:4], 4'h0};
  assign snoop_dway_o   = way_r;
  assign snoop_d_o      = snoop_d_s;
  assign snoop_dstrb_o  = snoop_dstrb_s;
  assign snoop_taddr_o  = {paddr_r[11:4], 4'h0};
  assign snoop_twe_o    = snoop_twe_s;
  assign snoop_tag_o    = {paddr_r[31:12], 1'b1, wp_r};

endmodule
